// File: rtl/finish_line_detector.sv
// Finish-line marker detector: debounces the all-sensors-active marker and emits one lap_pulse per crossing.
// Optional macro FINISH_SKIP_FIRST_EN suppresses the pulse for the first accepted crossing after reset.
module finish_line_detector #(
    parameter int   NUM_SENZORI   = 5,
    parameter logic SENSOR_ACTIVE = 1'b1,
    parameter int   DEBOUNCE_CYC  = 1000,
    parameter int   HOLDOFF_CYC   = 50_000_000
) (
    input  logic                   tact,
    input  logic                   reset,
    input  logic [NUM_SENZORI-1:0] senzori,
    input  logic                   enable,
    output logic                   lap_pulse,
    output logic                   marker_det,
    output logic                   busy,
    output logic [2:0]             stare
);

    localparam int CNT_MAX = (DEBOUNCE_CYC > HOLDOFF_CYC) ? DEBOUNCE_CYC : HOLDOFF_CYC;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYC - 1);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLDOFF_CYC - 1);

    typedef enum logic [2:0] {
        ARMED      = 3'd0,
        CONFIRM    = 3'd1,
        PULSE      = 3'd2,
        HOLDOFF    = 3'd3,
        WAIT_CLEAR = 3'd4
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [NUM_SENZORI-1:0] sync1_q, sync2_q;
    logic                   marker_q;
    logic                   mk;

    assign mk = (sync2_q == {NUM_SENZORI{SENSOR_ACTIVE}});

    always_ff @(posedge tact) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            marker_q <= 1'b0;
            state_q  <= ARMED;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= senzori;
            sync2_q  <= sync1_q;
            marker_q <= mk;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ARMED: begin
                if (mk) begin
                    cnt_d   = CW'(1);
                    state_d = (DEBOUNCE_CYC == 1) ? PULSE : CONFIRM;
                end else begin
                    cnt_d = '0;
                end
            end
            CONFIRM: begin
                // A marker that drops before the full debounce window is a partial/diagonal crossing.
                if (!mk) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = PULSE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PULSE: begin
                state_d = HOLDOFF;
                cnt_d   = '0;
            end
            HOLDOFF: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = WAIT_CLEAR;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_CLEAR: begin
                if (mk) begin
                    cnt_d = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = ARMED;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ARMED;
                cnt_d   = '0;
            end
        endcase
        if (!enable) begin
            state_d = ARMED;
            cnt_d   = '0;
        end
    end

`ifdef FINISH_SKIP_FIRST_EN
    // The first crossing is the start-line departure; it runs the full timing but is not counted.
    logic first_done_q;
    always_ff @(posedge tact) begin
        if (reset)
            first_done_q <= 1'b0;
        else if (state_q == PULSE)
            first_done_q <= 1'b1;
    end
    assign lap_pulse = (state_q == PULSE) && first_done_q;
`else
    assign lap_pulse = (state_q == PULSE);
`endif

    assign marker_det = marker_q;
    assign busy       = (state_q != ARMED);
    assign stare      = state_q;

endmodule

// File: tb/tb_finish_line_detector.sv
// Directed bench for finish_line_detector with DEBOUNCE_CYC=4, HOLDOFF_CYC=10.
module tb_finish_line_detector;

    localparam int N = 5;
`ifdef FINISH_SKIP_FIRST_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif
    // Expected lap_pulse level for the first crossing after a reset.
    localparam logic P1 = SKIP ? 1'b0 : 1'b1;

    logic         tact = 1'b0;
    logic         reset;
    logic         enable;
    logic [N-1:0] senzori;
    logic         lap_pulse, marker_det, busy;
    logic [2:0]   stare;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;

    finish_line_detector #(
        .NUM_SENZORI  (N),
        .SENSOR_ACTIVE(1'b1),
        .DEBOUNCE_CYC (4),
        .HOLDOFF_CYC  (10)
    ) dut (
        .tact      (tact),
        .reset     (reset),
        .senzori   (senzori),
        .enable    (enable),
        .lap_pulse (lap_pulse),
        .marker_det(marker_det),
        .busy      (busy),
        .stare     (stare)
    );

    always #5 tact = ~tact;

    // Stand-in for the downstream lap counter.
    always @(negedge tact) if (lap_pulse === 1'b1) pulses++;

    typedef struct {
        logic       rst;
        logic       en;
        logic [4:0] s;
        int         reps;
        logic [5:0] exp;   // {lap_pulse, marker_det, busy, stare}
    } vec_t;

    vec_t tv[13];

    task automatic step(input int n);
        repeat (n) @(posedge tact);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [5:0] outs();
        return {lap_pulse, marker_det, busy, stare};
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
    endtask

    task automatic crossing(input int mark, input int gap);
        senzori = 5'b11111;
        step(mark);
        senzori = 5'b00000;
        step(gap);
    endtask

    initial begin
        int p0;
        reset   = 1'b1;
        enable  = 1'b1;
        senzori = 5'b11111;

        // Reset, then first crossing latency and full state walk cycle by cycle.
        tv[0]  = '{1'b1, 1'b1, 5'h1F, 2, {1'b0, 1'b0, 1'b0, 3'd0}};
        tv[1]  = '{1'b0, 1'b1, 5'h1F, 1, {1'b0, 1'b0, 1'b0, 3'd0}};
        tv[2]  = '{1'b0, 1'b1, 5'h1F, 1, {1'b0, 1'b0, 1'b0, 3'd0}};
        tv[3]  = '{1'b0, 1'b1, 5'h1F, 1, {1'b0, 1'b1, 1'b1, 3'd1}};
        tv[4]  = '{1'b0, 1'b1, 5'h1F, 2, {1'b0, 1'b1, 1'b1, 3'd1}};
        tv[5]  = '{1'b0, 1'b1, 5'h1F, 1, {P1,   1'b1, 1'b1, 3'd2}};
        tv[6]  = '{1'b0, 1'b1, 5'h1F, 1, {1'b0, 1'b1, 1'b1, 3'd3}};
        tv[7]  = '{1'b0, 1'b1, 5'h1F, 9, {1'b0, 1'b1, 1'b1, 3'd3}};
        tv[8]  = '{1'b0, 1'b1, 5'h1F, 1, {1'b0, 1'b1, 1'b1, 3'd4}};
        tv[9]  = '{1'b0, 1'b1, 5'h00, 2, {1'b0, 1'b1, 1'b1, 3'd4}};
        tv[10] = '{1'b0, 1'b1, 5'h00, 1, {1'b0, 1'b0, 1'b1, 3'd4}};
        tv[11] = '{1'b0, 1'b1, 5'h00, 2, {1'b0, 1'b0, 1'b1, 3'd4}};
        tv[12] = '{1'b0, 1'b1, 5'h00, 1, {1'b0, 1'b0, 1'b0, 3'd0}};

        for (int i = 0; i < 13; i++) begin
            reset   = tv[i].rst;
            enable  = tv[i].en;
            senzori = tv[i].s;
            step(tv[i].reps);
            chk($sformatf("vec%0d", i), 32'(outs()), 32'(tv[i].exp));
        end

        // Glitch: 3 marker cycles then a dropped sensor must not pulse.
        p0 = pulses;
        senzori = 5'b11111;
        step(3);
        senzori = 5'b11101;
        step(20);
        chk("glitch_stare", 32'(stare), 32'd0);
        senzori = 5'b01111;
        step(100);
        chk("partial_stare", 32'(stare), 32'd0);
        chk("glitch_pulses", 32'(pulses - p0), 32'd0);

        // Long marker: one pulse; re-arm exactly after 4 clear samples.
        p0 = pulses;
        senzori = 5'b11111;
        step(200);
        senzori = 5'b00000;
        step(5);
        chk("long_wait_clear", 32'({busy, stare}), 32'({1'b1, 3'd4}));
        step(1);
        chk("long_rearmed", 32'({busy, stare}), 32'({1'b0, 3'd0}));
        step(5);
        chk("long_pulses", 32'(pulses - p0), 32'd1);

        // Two well-separated crossings count twice.
        p0 = pulses;
        crossing(20, 30);
        crossing(20, 30);
        chk("two_cross_pulses", 32'(pulses - p0), 32'd2);

        // Second marker inside holdoff is ignored.
        p0 = pulses;
        crossing(8, 5);
        crossing(8, 30);
        chk("holdoff_pulses", 32'(pulses - p0), 32'd1);

        // enable low while confirming.
        p0 = pulses;
        senzori = 5'b11111;
        step(3);
        chk("en_confirm", 32'(stare), 32'd1);
        enable = 1'b0;
        step(1);
        chk("en_armed", 32'({busy, stare}), 32'({1'b0, 3'd0}));
        step(10);
        chk("en_held", 32'(stare), 32'd0);
        senzori = 5'b00000;
        enable  = 1'b1;
        step(10);
        chk("en_pulses", 32'(pulses - p0), 32'd0);

        // Reset during holdoff, then a crossing is accepted right away.
        senzori = 5'b11111;
        step(7);
        chk("rst_in_holdoff", 32'(stare), 32'd3);
        reset = 1'b1;
        step(1);
        chk("rst_outputs", 32'(outs()), 32'd0);
        reset = 1'b0;
        step(4);
        chk("rst_k3", 32'({lap_pulse, stare}), 32'({1'b0, 3'd1}));
        step(1);
        chk("rst_k4", 32'({lap_pulse, stare}), 32'({1'b0, 3'd1}));
        step(1);
        chk("rst_k5", 32'({lap_pulse, stare}), 32'({P1, 3'd2}));
        senzori = 5'b00000;
        step(30);

        // Three crossings from a fresh reset.
        do_reset();
        step(5);
        p0 = pulses;
        crossing(20, 30);
        crossing(20, 30);
        crossing(20, 30);
        chk("three_cross_pulses", 32'(pulses - p0), SKIP ? 32'd2 : 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
